// File: rtl/adjust_pkg.sv
// ============================================================================
// adjust_pkg : shared types and constants for the clock adjust controller
// Rev 1.0
// ============================================================================
`default_nettype none

package adjust_pkg;

  typedef enum logic [1:0] {
    CLOCK  = 2'd0,
    ADJUST = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_THR  = 2'd0;
  localparam logic [1:0] SEL_TMIN = 2'd1;
  localparam logic [1:0] SEL_AHR  = 2'd2;
  localparam logic [1:0] SEL_AMIN = 2'd3;

  localparam int DEF_HR_MOD  = 24;
  localparam int DEF_MIN_MOD = 60;
  localparam int HR_W        = 5;
  localparam int MIN_W       = 6;

  function automatic logic [3:0] sel_onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_updown.sv
// ============================================================================
// mod_updown : loadable modulo-MOD register that steps up or down with wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_updown #(
  parameter int MOD   = 24,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             dn,
  output logic [WIDTH-1:0] val
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (en && up && !dn) begin
      val <= (val == MAX_VAL) ? '0 : val + 1'b1;
    end else if (en && dn && !up) begin
      val <= (val == '0) ? MAX_VAL : val - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adjust_controller.sv
// ============================================================================
// adjust_controller : button-driven adjust-mode sequencer for time and alarm
// Rev 1.0
// ============================================================================
`default_nettype none

module adjust_controller
  import adjust_pkg::*;
#(
  parameter int HR_MOD  = DEF_HR_MOD,
  parameter int MIN_MOD = DEF_MIN_MOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_c,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  output logic       adj_mode,
  output logic [1:0] sel,
  output logic [4:0] edit_hr,
  output logic [5:0] edit_min,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       time_load,
  output logic [3:0] leds
);

  state_t state;

  logic             capture;
  logic             adj_active;
  logic             nav;
  logic             step_en;
  logic [1:0]       sel_next;
  logic [HR_W-1:0]  cap_hr;
  logic [MIN_W-1:0] cap_min;

  // Priority decode: centre beats navigation beats value stepping.
  always_comb begin
    capture    = (state == CLOCK) && btn_c;
    adj_active = (state == ADJUST) && !btn_c;
    nav        = adj_active && (btn_l ^ btn_r);
    step_en    = adj_active && !btn_l && !btn_r && (btn_u ^ btn_d);
    sel_next   = btn_r ? sel + 2'd1 : sel - 2'd1;
    cap_hr     = (32'(cur_hr)  < HR_MOD)  ? cur_hr  : '0;
    cap_min    = (32'(cur_min) < MIN_MOD) ? cur_min : '0;
  end

  mod_updown #(.MOD(HR_MOD), .WIDTH(HR_W)) u_time_hr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .load_val (cap_hr),
    .en       (step_en && (sel == SEL_THR)),
    .up       (btn_u),
    .dn       (btn_d),
    .val      (edit_hr)
  );

  mod_updown #(.MOD(MIN_MOD), .WIDTH(MIN_W)) u_time_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .load_val (cap_min),
    .en       (step_en && (sel == SEL_TMIN)),
    .up       (btn_u),
    .dn       (btn_d),
    .val      (edit_min)
  );

  mod_updown #(.MOD(HR_MOD), .WIDTH(HR_W)) u_alarm_hr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .en       (step_en && (sel == SEL_AHR)),
    .up       (btn_u),
    .dn       (btn_d),
    .val      (alarm_hr)
  );

  mod_updown #(.MOD(MIN_MOD), .WIDTH(MIN_W)) u_alarm_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .en       (step_en && (sel == SEL_AMIN)),
    .up       (btn_u),
    .dn       (btn_d),
    .val      (alarm_min)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLOCK;
      sel       <= SEL_THR;
      adj_mode  <= 1'b0;
      time_load <= 1'b0;
      leds      <= 4'b0000;
    end else begin
      case (state)
        CLOCK: begin
          time_load <= 1'b0;
          if (btn_c) begin
            state    <= ADJUST;
            sel      <= SEL_THR;
            adj_mode <= 1'b1;
            leds     <= sel_onehot(SEL_THR);
          end
        end
        ADJUST: begin
          if (btn_c) begin
            state     <= COMMIT;
            adj_mode  <= 1'b0;
            leds      <= 4'b0000;
            time_load <= 1'b1;
          end else if (nav) begin
            sel  <= sel_next;
            leds <= sel_onehot(sel_next);
          end
        end
        COMMIT: begin
          state     <= CLOCK;
          time_load <= 1'b0;
        end
        default: begin
          state     <= CLOCK;
          adj_mode  <= 1'b0;
          time_load <= 1'b0;
          leds      <= 4'b0000;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/adjust_controller.md
Name: adjust_controller

Overview:
Sequencing controller for the clock's adjust mode. It takes the five push-button pulses (centre, left, right, up, down) and switches between normal clock display and adjust mode. It selects which field is being edited, steps the field value with wrap-around, and holds the alarm setting. On exit it commits the edited time to the timekeeping counter with a one-cycle load strobe; the segment/display logic reads its outputs.

Parameters:
HR_MOD, 24, hour field modulus (values 0..HR_MOD-1)
MIN_MOD, 60, minute field modulus (values 0..MIN_MOD-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
btn_c  in  1  centre button, single-cycle pulse (already debounced and edge-detected upstream)
btn_l  in  1  left button pulse
btn_r  in  1  right button pulse
btn_u  in  1  up button pulse
btn_d  in  1  down button pulse
cur_hr  in  5  live hour from timekeeper
cur_min  in  6  live minute from timekeeper
adj_mode  out  1  high while editing
sel  out  2  selected field: 0 time-hr, 1 time-min, 2 alarm-hr, 3 alarm-min
edit_hr  out  5  working copy of time hour
edit_min  out  6  working copy of time minute
alarm_hr  out  5  stored alarm hour
alarm_min  out  6  stored alarm minute
time_load  out  1  one-cycle strobe: timekeeper loads edit_hr/edit_min
leds  out  4  one-hot of sel while adj_mode, else 0

Behaviour:
- All outputs are registered. A button pulse in cycle n is visible on outputs in cycle n+1.
- Reset (rst_n=0 at a clk edge) puts the FSM in CLOCK with sel=0, edit_hr=0, edit_min=0, alarm_hr=0, alarm_min=0, adj_mode=0, time_load=0, leds=0.
- Reset during ADJUST or COMMIT discards the edits. No time_load pulse is issued.
- States: CLOCK, ADJUST, COMMIT.
- CLOCK:
  - btn_c -> ADJUST. Capture edit_hr<=cur_hr and edit_min<=cur_min; set sel<=0.
  - A captured value that is out of range (cur_hr>=HR_MOD or cur_min>=MIN_MOD) is captured as 0.
  - btn_l/r/u/d are ignored.
- ADJUST (adj_mode=1):
  - Priority when buttons coincide: btn_c > navigation (l/r) > value (u/d). At most one action per cycle.
  - btn_c -> COMMIT.
  - btn_r: sel<=sel+1, wrapping 3->0. btn_l: sel<=sel-1, wrapping 0->3.
  - btn_l and btn_r together: no action. Lower-priority u/d are also not applied that cycle.
  - btn_u: selected field +1. Hour wraps HR_MOD-1 -> 0; minute wraps MIN_MOD-1 -> 0.
  - btn_d: selected field -1. Hour wraps 0 -> HR_MOD-1; minute wraps 0 -> MIN_MOD-1.
  - btn_u and btn_d together: no change.
  - A minute field has no carry or borrow into its hour field.
  - Alarm fields take effect immediately; they need no commit.
- COMMIT (exactly one cycle):
  - time_load=1 with edit_hr/edit_min stable; adj_mode=0; leds=0.
  - All buttons are ignored.
  - Next state is CLOCK.
- After COMMIT, edit_hr/edit_min hold their values until the next entry into ADJUST.
- sel is held in CLOCK and reset to 0 on each entry into ADJUST.
- time_load is never high outside COMMIT and never high two cycles in a row.

Decomposition:
- Shared package adjust_pkg holds:
  - the state enum (CLOCK, ADJUST, COMMIT)
  - field-select constants SEL_THR=0, SEL_TMIN=1, SEL_AHR=2, SEL_AMIN=3
  - default moduli 24 and 60
  - hour/minute width constants (5, 6)
- One sub-module, mod_updown: a wrapping up/down register with parameter MOD and WIDTH. Inputs clk, rst_n, load, load_val, en, up, dn; output val.
- The controller instantiates mod_updown four times, one per field. The FSM drives the en/up/dn/load decode.

Test Plan:
- Reset, then btn_c with cur=13:45 -> next cycle adj_mode=1, sel=0, leds=0001, edit=13:45; btn_c again -> one cycle time_load=1 with edit=13:45, then adj_mode=0.
- In ADJUST, sel=0, edit_hr=23, btn_u -> edit_hr=0; btn_d -> 23; btn_r then btn_d with edit_min=0 -> edit_min=59, edit_hr unchanged.
- Navigation wrap: sel=0, btn_l -> sel=3, leds=1000; btn_r -> sel=0; btn_l and btn_r in the same cycle -> sel unchanged.
- Alarm edit: sel=2, three btn_u pulses from reset -> alarm_hr=3; sel=3, btn_d -> alarm_min=59; exit -> alarm holds 03:59, time_load carries only edit values.
- Simultaneous events: btn_c+btn_u in ADJUST -> COMMIT, field not incremented; btn_u+btn_d -> no change; btn_u in CLOCK -> no output change.
- Reset mid-ADJUST after editing edit_hr=7 -> CLOCK, all outputs at reset values, no time_load pulse; out-of-range capture cur_hr=25 -> edit_hr=0.
